// File: rtl/fifo_word_serializer.sv
// Drains a FIFO one word at a time onto a single-wire async line (start, LSB-first data, stop).
// Latency: Fifo_RE one cycle after IDLE sees a non-empty FIFO; start bit two cycles after Fifo_RE.
// Backpressure: FIFO is popped only between frames; EN low lets the current frame finish, then idles.
module fifo_word_serializer #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  EN,
  input  logic                  Fifo_Empty,
  input  logic [DATA_WIDTH-1:0] Fifo_Read_Data,
  output logic                  Fifo_RE,
  output logic                  Tx_Serial,
  output logic                  Busy,
  output logic                  Word_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    fifo_re_q, fifo_re_d;
  logic                    tx_q, tx_d;
  logic                    word_done_q, word_done_d;

  // Next-state, counter and shift-register logic; outputs are derived from the next state
  // so that every output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    word_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (EN && !Fifo_Empty) begin
          state_d = REQ;
        end
      end
      REQ: begin
        state_d = LOAD;
      end
      LOAD: begin
        // Read_Data was updated by the FIFO on the edge that ended REQ.
        shift_d   = Fifo_Read_Data;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d   = '0;
          state_d     = IDLE;
          word_done_d = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    // Read strobe is high exactly for the REQ cycle.
    fifo_re_d = (state_d == REQ);

    // Line level for the cycle about to start: low for start, LSB of the shifter for data, else idle high.
    tx_d = 1'b1;
    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shift_d[0];
    end
  end

  // State register with asynchronous clear; a word already popped is dropped on reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      fifo_re_q   <= 1'b0;
      tx_q        <= 1'b1;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      fifo_re_q   <= fifo_re_d;
      tx_q        <= tx_d;
      word_done_q <= word_done_d;
    end
  end

  assign Fifo_RE   = fifo_re_q;
  assign Tx_Serial = tx_q;
  assign Word_Done = word_done_q;
  assign Busy      = (state_q != IDLE);

endmodule
